// File: rtl/rr_dec_seq.sv
// rr_dec_seq
//   Round-robin sequencer for a downstream 2-to-4 decoder. It grants one
//   requesting channel at a time. During a grant it holds E high for DWELL
//   cycles and presents the channel number on A. It then forces at least one
//   E-low cycle before the next grant, so the decoder breaks before it makes.
//
// Parameters
//   DWELL : cycles E stays high per grant, 1..15
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   req  : per-channel requests, bit n maps to decoder output n
//   A    : registered channel select (decoder A input)
//   E    : registered decoder enable (decoder E input)
//   busy : high whenever the FSM is not in IDLE
//   done : one-cycle pulse in the last E-high cycle of each grant
//
// State table
//   IDLE  | no grant pending, E low, A holds last channel
//   GRANT | E high, counting down the dwell
//   GAP   | mandatory E-low cycle between grants, arbitrates again

module rr_dec_seq #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [1:0] A,
  output logic       E,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(DWELL - 1);

  state_t     state;
  logic [1:0] ptr;
  logic [3:0] cnt;

  logic [1:0] sel;
  logic [1:0] idx;
  logic       found;
  logic       any_req;

  // Search order is ptr+1, ptr+2, ptr+3 and finally ptr itself. The channel
  // granted last therefore has the lowest priority.
  always_comb begin
    sel   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any_req = |req;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      A     <= 2'd0;
      E     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= 4'd0;
      ptr   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (any_req) begin
            state <= GRANT;
            A     <= sel;
            ptr   <= sel;
            E     <= 1'b1;
            busy  <= 1'b1;
            cnt   <= CNT_LOAD;
            // When DWELL is 1, the first grant cycle is also the last one.
            done  <= (CNT_LOAD == 4'd0);
          end else begin
            E    <= 1'b0;
            busy <= 1'b0;
          end
        end

        GRANT: begin
          if (cnt == 4'd0) begin
            state <= GAP;
            E     <= 1'b0;
            done  <= 1'b0;
          end else begin
            cnt  <= cnt - 4'd1;
            // done must be high in the cycle where cnt reads 0, so it is
            // set one edge early, while cnt is still 1.
            done <= (cnt == 4'd1);
          end
        end

        GAP: begin
          done <= 1'b0;
          if (any_req) begin
            state <= GRANT;
            A     <= sel;
            ptr   <= sel;
            E     <= 1'b1;
            cnt   <= CNT_LOAD;
            done  <= (CNT_LOAD == 4'd0);
          end else begin
            state <= IDLE;
            E     <= 1'b0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          E     <= 1'b0;
          busy  <= 1'b0;
          done  <= 1'b0;
          cnt   <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_dec_seq.sv
// Testbench for rr_dec_seq. Two instances run side by side, one with DWELL=4
// and one with DWELL=1. Both share req and rst. A behavioural model tracks
// the remaining grant cycles, the gap flag, the granted channel and the
// priority pointer. A negedge process compares every output to the model on
// every cycle. Directed scenarios pin the model with literal expectations,
// and a randomized phase follows.

module tb_rr_dec_seq;

  logic       clk;
  logic       rst;
  logic [3:0] req;

  logic [1:0] a4, a1;
  logic       e4, e1, busy4, busy1, done4, done1;

  int checks   = 0;
  int failures = 0;
  logic check_en = 1'b0;

  rr_dec_seq #(.DWELL(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .A(a4), .E(e4), .busy(busy4), .done(done4)
  );

  rr_dec_seq #(.DWELL(1)) dut1 (
    .clk(clk), .rst(rst), .req(req),
    .A(a1), .E(e1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: "left" counts the E-high cycles still owed to the
  // current grant. "gap" marks the single forced-low cycle after a grant.
  typedef struct packed {
    logic [3:0] left;
    logic       gap;
    logic [1:0] ch;
    logic [1:0] ptr;
  } mdl_t;

  localparam mdl_t MDL_RST = '{left: 4'd0, gap: 1'b0, ch: 2'd0, ptr: 2'd3};

  mdl_t m4 = MDL_RST;
  mdl_t m1 = MDL_RST;

  function automatic mdl_t next_model(mdl_t m, logic r, logic [3:0] rq, int dwell);
    mdl_t       n;
    logic [1:0] c;
    logic       hit;
    n = m;
    if (r) begin
      n = MDL_RST;
    end else if (m.left != 0) begin
      n.left = m.left - 4'd1;
      if (n.left == 0) n.gap = 1'b1;
    end else if (rq != 4'd0) begin
      hit = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = m.ptr + 2'(k);
        if (!hit && rq[c]) begin
          hit   = 1'b1;
          n.ch  = c;
          n.ptr = c;
        end
      end
      n.left = 4'(dwell);
      n.gap  = 1'b0;
    end else begin
      n.gap = 1'b0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 <= next_model(m4, rst, req, 4);
    m1 <= next_model(m1, rst, req, 1);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Channels captured on each E rising edge, per instance.
  logic [1:0] q4[$];
  logic [1:0] q1[$];
  logic prev_e4 = 1'b0;
  logic prev_e1 = 1'b0;

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_A4",    {2'b0, a4},    {2'b0, m4.ch});
      chk("model_E4",    {3'b0, e4},    {3'b0, (m4.left != 0)});
      chk("model_busy4", {3'b0, busy4}, {3'b0, (m4.left != 0) || m4.gap});
      chk("model_done4", {3'b0, done4}, {3'b0, (m4.left == 1)});
      chk("model_A1",    {2'b0, a1},    {2'b0, m1.ch});
      chk("model_E1",    {3'b0, e1},    {3'b0, (m1.left != 0)});
      chk("model_busy1", {3'b0, busy1}, {3'b0, (m1.left != 0) || m1.gap});
      chk("model_done1", {3'b0, done1}, {3'b0, (m1.left == 1)});
      if (e4 && !prev_e4) q4.push_back(a4);
      if (e1 && !prev_e1) q1.push_back(a1);
      prev_e4 = e4;
      prev_e1 = e1;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_e [6];
    logic exp_d [6];
    int   dcount;
    exp_e = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset held for two cycles with every request asserted.
    rst = 1'b1;
    req = 4'hF;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_A",    {2'b0, a4},    4'd0);
      chk("rst_E",    {3'b0, e4},    4'd0);
      chk("rst_busy", {3'b0, busy4}, 4'd0);
      chk("rst_done", {3'b0, done4}, 4'd0);
    end

    // A single held request on channel 2 is granted, dwells, gaps and regrants.
    rst = 1'b0;
    req = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("ch2_E",    {3'b0, e4},    {3'b0, exp_e[i]});
      chk("ch2_done", {3'b0, done4}, {3'b0, exp_d[i]});
      if (exp_e[i]) chk("ch2_A", {2'b0, a4}, 4'd2);
    end

    // All channels requesting: strict round-robin starting at channel 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'hF;
    q4.delete();
    repeat (25) step();
    chk("rr_count", (q4.size() >= 5) ? 4'd1 : 4'd0, 4'd1);
    if (q4.size() >= 5) begin
      chk("rr_0", {2'b0, q4[0]}, 4'd0);
      chk("rr_1", {2'b0, q4[1]}, 4'd1);
      chk("rr_2", {2'b0, q4[2]}, 4'd2);
      chk("rr_3", {2'b0, q4[3]}, 4'd3);
      chk("rr_4", {2'b0, q4[4]}, 4'd0);
    end

    // A one-cycle pulse on channel 0 still yields a full grant and one done.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0001;
    step();
    req = 4'b0000;
    dcount = done4 ? 1 : 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done4) dcount++;
    end
    chk("pulse_done_cnt", 4'(dcount), 4'd1);
    chk("pulse_idle_busy", {3'b0, busy4}, 4'd0);

    // Reset in the second grant cycle abandons the grant without a done pulse.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0100;
    step();
    step();
    rst = 1'b1;
    step();
    chk("abort_E",    {3'b0, e4},    4'd0);
    chk("abort_A",    {2'b0, a4},    4'd0);
    chk("abort_done", {3'b0, done4}, 4'd0);
    rst = 1'b0;
    req = 4'b1000;
    step();
    chk("after_abort_A", {2'b0, a4}, 4'd3);
    chk("after_abort_E", {3'b0, e4}, 4'd1);

    // With DWELL=1 and channel 1 just granted, channel 3 is served before channel 1.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b0010;
    q1.delete();
    step();
    chk("d1_E",    {3'b0, e1},    4'd1);
    chk("d1_done", {3'b0, done1}, 4'd1);
    chk("d1_A",    {2'b0, a1},    4'd1);
    req = 4'b1010;
    repeat (5) step();
    req = 4'b0000;
    chk("d1_count", (q1.size() >= 3) ? 4'd1 : 4'd0, 4'd1);
    if (q1.size() >= 3) begin
      chk("d1_seq0", {2'b0, q1[0]}, 4'd1);
      chk("d1_seq1", {2'b0, q1[1]}, 4'd3);
      chk("d1_seq2", {2'b0, q1[2]}, 4'd1);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      req = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0;
    req = 4'b0000;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
